ks_sched: RTL and testbench

Keystream scheduler for the ChaCha20 encryption path. Sequences the ChaCha20 block core, one 512-bit block per request, with an incrementing 32-bit block counter. Loads each finished block into the 8×128-bit keystream buffer, which is written as four 128-bit words per block. Grants 128-bit reads to the XOR datapath while tracking buffer occupancy, and realigns the buffer's free-running read pointer at the end of every message.

---
 rtl/ks_pkg.sv | 10 +
 rtl/ks_occ_cnt.sv | 24 ++
 rtl/ks_sched.sv | 104 ++++++++++
 tb/tb_ks_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// ks_pkg: shared FSM states, buffer geometry and counter clamp for the keystream scheduler.
package ks_pkg;
  typedef enum logic [2:0] {IDLE, REQ, RUN, LOAD, FILL, DRAIN} state_t;
  localparam int BLK_WORDS = 4;
  localparam int BUF_WORDS = 8;
  localparam int FILL_CYC = 4;
  function automatic int clamp(input int v, input int hi);
    return v < 0 ? 0 : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/ks_occ_cnt.sv
// ks_occ_cnt: reserved/avail buffer word counters with simultaneous add and read, clamped to 0..MAX.
module ks_occ_cnt
  import ks_pkg::*;
#(
  parameter int MAX = BUF_WORDS,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic         fill,
  input  logic         rd,
  output logic [W-1:0] reserved,
  output logic [W-1:0] avail
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      reserved <= '0;
      avail <= '0;
    end else begin
      reserved <= W'(clamp(int'(reserved) + (req ? BLK_WORDS : 0) - int'(rd), MAX));
      avail <= W'(clamp(int'(avail) + (fill ? BLK_WORDS : 0) - int'(rd), MAX));
    end
endmodule

// File: rtl/ks_sched.sv
// ks_sched: ChaCha20 keystream scheduler sequencing the block core and the 2-block keystream buffer.
// Define KS_PREFETCH_EN to let the core compute the next block while the previous one is read.
module ks_sched #(
  parameter int CNT_W = 32,
  parameter int LEN_W = 16,
  parameter int BUF_WORDS = ks_pkg::BUF_WORDS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_init_cnt,
  input  logic [LEN_W-1:0] i_len_words,
  output logic             o_core_start,
  output logic [CNT_W-1:0] o_core_cnt,
  input  logic             i_core_done,
  output logic             o_w_en,
  input  logic             i_rd_req,
  output logic             o_r_en,
  output logic             o_rd_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  import ks_pkg::*;
  localparam int OW = $clog2(BUF_WORDS + 1);
  localparam int FW = $clog2(FILL_CYC);
  state_t state, state_n;
  logic [LEN_W-1:0] words_left, blocks_left;
  logic [FW-1:0] fill_cnt;
  logic [1:0] dummy;
  logic [OW-1:0] reserved, avail;
  logic wrapped, space, req_fire, fill_exit, fin, accept, real_rd, dummy_rd;
`ifdef KS_PREFETCH_EN
  assign space = int'(reserved) <= BUF_WORDS - BLK_WORDS;
`else
  assign space = reserved == '0;
`endif
  assign fin = state == DRAIN && words_left == '0 && dummy == '0;
  assign o_busy = state != IDLE && !fin;
  assign o_done = fin;
  assign accept = i_start && !o_busy;
  assign req_fire = state == REQ && space;
  assign fill_exit = state == FILL && fill_cnt == FW'(FILL_CYC - 1);
  assign real_rd = i_rd_req && avail != '0 && words_left != '0;
  // Dummy reads walk the free-running read pointer back to a block boundary.
  assign dummy_rd = state == DRAIN && words_left == '0 && dummy != '0;
  assign o_r_en = real_rd || dummy_rd;
  assign o_core_start = req_fire;
  assign o_w_en = state == LOAD;
  ks_occ_cnt #(.MAX(BUF_WORDS), .W(OW)) u_occ (
    .clk(i_clk), .rst(i_rst), .req(req_fire), .fill(fill_exit), .rd(o_r_en),
    .reserved(reserved), .avail(avail)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = IDLE;
      REQ:     state_n = space ? RUN : REQ;
      RUN:     state_n = i_core_done ? LOAD : RUN;
      LOAD:    state_n = FILL;
      FILL:    state_n = !fill_exit ? FILL : (blocks_left != '0 && !wrapped) ? REQ : DRAIN;
      DRAIN:   state_n = fin ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
    if (accept) state_n = i_len_words == '0 ? DRAIN : REQ;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      o_core_cnt <= '0;
      words_left <= '0;
      blocks_left <= '0;
      fill_cnt <= '0;
      dummy <= '0;
      wrapped <= 1'b0;
      o_rd_valid <= 1'b0;
      o_err <= 1'b0;
    end else begin
      state <= state_n;
      o_rd_valid <= real_rd;
      fill_cnt <= state == FILL ? fill_cnt + FW'(1) : '0;
      if (accept) begin
        o_core_cnt <= i_init_cnt;
        words_left <= i_len_words;
        blocks_left <= (i_len_words >> 2) + LEN_W'(|i_len_words[1:0]);
        dummy <= 2'd0 - i_len_words[1:0];
        wrapped <= 1'b0;
        o_err <= 1'b0;
      end else begin
        if (state == LOAD) begin
          o_core_cnt <= o_core_cnt + CNT_W'(1);
          blocks_left <= blocks_left - LEN_W'(1);
          wrapped <= wrapped | (&o_core_cnt);
        end
        // On counter overflow only the blocks already requested are delivered.
        if (fill_exit && wrapped && blocks_left != '0) begin
          o_err <= 1'b1;
          words_left <= LEN_W'(reserved) - LEN_W'(real_rd);
          dummy <= '0;
        end else if (real_rd) words_left <= words_left - LEN_W'(1);
        if (dummy_rd) dummy <= dummy - 2'd1;
      end
    end
endmodule

// File: tb/tb_ks_sched.sv
// tb_ks_sched: randomized self-checking bench for ks_sched with a core model and a keystream buffer model.
module tb_ks_sched;
  logic clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_core_done = 1'b0, i_rd_req = 1'b0;
  logic [31:0] i_init_cnt = '0;
  logic [15:0] i_len_words = '0;
  logic o_core_start, o_w_en, o_r_en, o_rd_valid, o_busy, o_done, o_err;
  logic [31:0] o_core_cnt;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [33:0] bufm [8];
  logic [33:0] prev_data = '0;
  logic [33:0] got [$];
  int val_cyc [$], cs_cyc [$];
  logic [31:0] cs_cnt [$];
  logic [31:0] core_tag = '0;
  int rp = 0, wp = 0, n_we = 0, n_ren = 0, n_dummy = 0, n_bad = 0, first_raddr = -1;
  int done_cyc = -1, last_ren = -1, t_done = -1, done_at = 0, core_lat = 3;
  bit prev_ren = 0, core_pend = 0, rd_cont = 1, done_err = 0, done_busy = 0;

  ks_sched dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_init_cnt(i_init_cnt), .i_len_words(i_len_words),
    .o_core_start(o_core_start), .o_core_cnt(o_core_cnt), .i_core_done(i_core_done), .o_w_en(o_w_en),
    .i_rd_req(i_rd_req), .o_r_en(o_r_en), .o_rd_valid(o_rd_valid), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core and XOR-side model: drives inputs on the falling edge, samples 1 time unit later.
  initial forever begin
    @(negedge clk);
    i_core_done = core_pend && cyc == done_at;
    i_rd_req = rd_cont ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    if (rst) begin
      rp = 0; wp = 0; prev_ren = 0; core_pend = 0; i_core_done = 0;
    end else begin
      if (i_core_done) begin core_pend = 0; if (t_done < 0) t_done = cyc; end
      if (o_core_start) begin
        core_pend = 1; done_at = cyc + core_lat; core_tag = o_core_cnt;
        cs_cyc.push_back(cyc); cs_cnt.push_back(o_core_cnt);
      end
      if (o_rd_valid) begin
        if (prev_ren) begin got.push_back(prev_data); val_cyc.push_back(cyc); end
        else n_bad++;
      end else if (prev_ren) n_dummy++;
      prev_ren = o_r_en;
      if (o_w_en) begin
        n_we++;
        for (int k = 0; k < 4; k++) bufm[(wp + k) % 8] = {core_tag, 2'(k)};
        wp = (wp + 4) % 8;
      end
      if (o_r_en) begin
        if (n_ren == 0) first_raddr = rp;
        prev_data = bufm[rp]; rp = (rp + 1) % 8; n_ren++; last_ren = cyc;
      end
      if (o_done && done_cyc < 0) begin done_cyc = cyc; done_err = o_err; done_busy = o_busy; end
    end
  end

  task automatic clr();
    got.delete(); val_cyc.delete(); cs_cyc.delete(); cs_cnt.delete();
    n_we = 0; n_ren = 0; n_dummy = 0; n_bad = 0; first_raddr = -1; done_cyc = -1; last_ren = -1; t_done = -1;
  endtask

  // Reference: blocks = ceil(len/4); the counter can serve 2^32-init blocks before wrapping.
  function automatic void model(input logic [31:0] init, input int len, output int v, output int d, output int cs, output bit e);
    longint blocks = longint'((len + 3) / 4);
    longint room = 64'sh1_0000_0000 - longint'({32'd0, init});
    e = blocks > room;
    cs = int'(e ? room : blocks);
    v = len < 4 * cs ? len : 4 * cs;
    d = e ? 0 : int'(4 * blocks) - len;
  endfunction

  task automatic run_msg(input logic [31:0] init, input int len, input int lat, input bit cont, input int poke, output int c0, output bit to);
    @(negedge clk);
    clr(); core_lat = lat; rd_cont = cont;
    i_init_cnt = init; i_len_words = 16'(len); i_start = 1; c0 = cyc;
    @(negedge clk);
    i_start = 0; to = 1;
    for (int i = 0; i < 3000; i++) begin
      #2;
      if (done_cyc >= 0) begin to = 0; break; end
      i_start = i == poke;
      if (i == poke) begin i_len_words = 16'd1; i_init_cnt = 32'h55; end
      @(negedge clk);
    end
    i_start = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; i_rd_req = 1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if ({o_core_start, o_w_en, o_r_en, o_rd_valid, o_busy, o_done, o_err, o_core_cnt} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, want 0", {o_core_start, o_w_en, o_r_en, o_rd_valid, o_busy, o_done, o_err, o_core_cnt}); end
    @(negedge clk); #2; rst = 0;
  endtask

  task automatic test_len0();
    int c0; bit to;
    run_msg(32'h10, 0, 3, 1, -1, c0, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL len0_timeout: got no o_done, want o_done"); end
    n_chk++; if (done_cyc !== c0 + 1) begin n_fail++; $display("FAIL len0_done_cycle: got %0d, want %0d", done_cyc, c0 + 1); end
    n_chk++; if (cs_cyc.size() + n_ren + n_we !== 0) begin n_fail++; $display("FAIL len0_activity: got starts=%0d ren=%0d wen=%0d, want 0", cs_cyc.size(), n_ren, n_we); end
    n_chk++; if (done_busy !== 0) begin n_fail++; $display("FAIL len0_busy_at_done: got %0d, want 0", done_busy); end
  endtask

  task automatic test_len4();
    int c0; bit to;
    run_msg(32'd1, 4, 10, 1, -1, c0, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL len4_timeout: got no o_done, want o_done"); end
    n_chk++; if (cs_cyc.size() !== 1 || cs_cnt[0] !== 32'd1) begin n_fail++; $display("FAIL len4_core_start: got n=%0d cnt=%0d, want n=1 cnt=1", cs_cyc.size(), cs_cnt[0]); end
    n_chk++; if (cs_cyc[0] !== c0 + 1) begin n_fail++; $display("FAIL len4_start_latency: got %0d, want %0d", cs_cyc[0], c0 + 1); end
    n_chk++; if (val_cyc[0] !== t_done + 7) begin n_fail++; $display("FAIL len4_first_valid: got %0d, want %0d", val_cyc[0], t_done + 7); end
    n_chk++; if (got.size() !== 4 || n_dummy !== 0 || n_bad !== 0) begin n_fail++; $display("FAIL len4_reads: got valid=%0d dummy=%0d bad=%0d, want 4/0/0", got.size(), n_dummy, n_bad); end
    n_chk++; if (done_cyc !== last_ren + 1 || done_busy !== 0) begin n_fail++; $display("FAIL len4_done: got cyc=%0d busy=%0d, want cyc=%0d busy=0", done_cyc, done_busy, last_ren + 1); end
    for (int k = 0; k < got.size(); k++) begin
      n_chk++; if (got[k] !== {32'd1 + 32'(k / 4), 2'(k % 4)}) begin n_fail++; $display("FAIL len4_word%0d: got %h, want %h", k, got[k], {32'd1 + 32'(k / 4), 2'(k % 4)}); end
    end
  endtask

  task automatic test_len6();
    int c0; bit to;
    logic [31:0] init = $urandom();
    init[31] = 1'b0;
    run_msg(init, 6, 3, 1, -1, c0, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL len6_timeout: got no o_done, want o_done"); end
    n_chk++; if (cs_cyc.size() !== 2 || cs_cnt[1] !== init + 32'd1) begin n_fail++; $display("FAIL len6_core_starts: got n=%0d cnt1=%h, want n=2 cnt1=%h", cs_cyc.size(), cs_cnt[1], init + 32'd1); end
`ifdef KS_PREFETCH_EN
    n_chk++; if (!(cs_cyc[1] < val_cyc[3] - 1)) begin n_fail++; $display("FAIL len6_prefetch: got second start %0d, want before 4th read %0d", cs_cyc[1], val_cyc[3] - 1); end
`else
    n_chk++; if (!(cs_cyc[1] > val_cyc[3] - 1)) begin n_fail++; $display("FAIL len6_single_buf: got second start %0d, want after 4th read %0d", cs_cyc[1], val_cyc[3] - 1); end
`endif
    n_chk++; if (got.size() !== 6 || n_dummy !== 2 || n_bad !== 0) begin n_fail++; $display("FAIL len6_reads: got valid=%0d dummy=%0d bad=%0d, want 6/2/0", got.size(), n_dummy, n_bad); end
    n_chk++; if (done_cyc !== last_ren + 1) begin n_fail++; $display("FAIL len6_done_after_dummy: got %0d, want %0d", done_cyc, last_ren + 1); end
    for (int k = 0; k < got.size(); k++) begin
      n_chk++; if (got[k] !== {init + 32'(k / 4), 2'(k % 4)}) begin n_fail++; $display("FAIL len6_word%0d: got %h, want %h", k, got[k], {init + 32'(k / 4), 2'(k % 4)}); end
    end
  endtask

  task automatic test_overflow();
    int c0; bit to;
    run_msg(32'hFFFF_FFFF, 8, 4, 1, -1, c0, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL ovf_timeout: got no o_done, want o_done"); end
    n_chk++; if (cs_cyc.size() !== 1) begin n_fail++; $display("FAIL ovf_core_starts: got %0d, want 1", cs_cyc.size()); end
    n_chk++; if (got.size() !== 4 || n_dummy !== 0) begin n_fail++; $display("FAIL ovf_reads: got valid=%0d dummy=%0d, want 4/0", got.size(), n_dummy); end
    n_chk++; if (done_err !== 1) begin n_fail++; $display("FAIL ovf_err_at_done: got %0d, want 1", done_err); end
    for (int k = 0; k < got.size(); k++) begin
      n_chk++; if (got[k] !== {32'hFFFF_FFFF, 2'(k)}) begin n_fail++; $display("FAIL ovf_word%0d: got %h, want %h", k, got[k], {32'hFFFF_FFFF, 2'(k)}); end
    end
    #1;
    n_chk++; if (o_err !== 1) begin n_fail++; $display("FAIL ovf_err_sticky: got %0d, want 1", o_err); end
    run_msg(32'd5, 4, 2, 1, -1, c0, to);
    n_chk++; if (to || done_err !== 0) begin n_fail++; $display("FAIL ovf_err_cleared: got timeout=%0d err=%0d, want 0/0", to, done_err); end
  endtask

  task automatic test_start_ignored();
    int c0; bit to;
    run_msg(32'h40, 7, 2, 0, 4, c0, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL busy_start_timeout: got no o_done, want o_done"); end
    n_chk++; if (got.size() !== 7 || n_dummy !== 1 || cs_cyc.size() !== 2) begin n_fail++; $display("FAIL busy_start_counts: got valid=%0d dummy=%0d starts=%0d, want 7/1/2", got.size(), n_dummy, cs_cyc.size()); end
    for (int k = 0; k < got.size(); k++) begin
      n_chk++; if (got[k] !== {32'h40 + 32'(k / 4), 2'(k % 4)}) begin n_fail++; $display("FAIL busy_start_word%0d: got %h, want %h", k, got[k], {32'h40 + 32'(k / 4), 2'(k % 4)}); end
    end
  endtask

  task automatic test_rst_mid();
    int c0; bit to, hit;
    hit = 0;
    @(negedge clk);
    clr(); core_lat = 3; rd_cont = 1; i_init_cnt = 32'h200; i_len_words = 16'd12; i_start = 1;
    @(negedge clk);
    i_start = 0;
    for (int i = 0; i < 300 && !hit; i++) begin #2; hit = n_we >= 2; if (!hit) @(negedge clk); end
    n_chk++; if (!hit) begin n_fail++; $display("FAIL rstmid_second_load: got %0d loads, want 2", n_we); end
    @(negedge clk); #3; rst = 1; #1;
    n_chk++; if ({o_core_start, o_w_en, o_r_en, o_rd_valid, o_busy, o_done, o_err, o_core_cnt} !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %h, want 0", {o_core_start, o_w_en, o_r_en, o_rd_valid, o_busy, o_done, o_err, o_core_cnt}); end
    @(negedge clk); #2; rst = 0;
    run_msg(32'h300, 4, 3, 1, -1, c0, to);
    n_chk++; if (to || got.size() !== 4) begin n_fail++; $display("FAIL rstmid_after: got timeout=%0d valid=%0d, want 0/4", to, got.size()); end
    n_chk++; if (first_raddr !== 0) begin n_fail++; $display("FAIL rstmid_read_addr: got %0d, want 0", first_raddr); end
    for (int k = 0; k < got.size(); k++) begin
      n_chk++; if (got[k] !== {32'h300, 2'(k)}) begin n_fail++; $display("FAIL rstmid_word%0d: got %h, want %h", k, got[k], {32'h300, 2'(k)}); end
    end
  endtask

  task automatic test_random();
    int c0, len, v, d, cs;
    bit to, e;
    logic [31:0] init;
    for (int r = 0; r < 10; r++) begin
      init = $urandom_range(0, 2) == 0 ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom();
      len = $urandom_range(0, 22);
      model(init, len, v, d, cs, e);
      run_msg(init, len, $urandom_range(1, 8), 1'($urandom_range(0, 1)), -1, c0, to);
      n_chk++; if (to) begin n_fail++; $display("FAIL rnd%0d_timeout: got no o_done, want o_done (len=%0d)", r, len); end
      n_chk++; if (got.size() !== v || n_dummy !== d || n_bad !== 0) begin n_fail++; $display("FAIL rnd%0d_reads: got valid=%0d dummy=%0d bad=%0d, want %0d/%0d/0", r, got.size(), n_dummy, n_bad, v, d); end
      n_chk++; if (cs_cyc.size() !== cs || done_err !== e) begin n_fail++; $display("FAIL rnd%0d_blocks: got starts=%0d err=%0d, want %0d/%0d", r, cs_cyc.size(), done_err, cs, e); end
      n_chk++; if (done_busy !== 0 || (len != 0 && done_cyc !== last_ren + 1)) begin n_fail++; $display("FAIL rnd%0d_done: got cyc=%0d busy=%0d, want cyc=%0d busy=0", r, done_cyc, done_busy, last_ren + 1); end
      for (int k = 0; k < got.size(); k++) begin
        n_chk++; if (got[k] !== {init + 32'(k / 4), 2'(k % 4)}) begin n_fail++; $display("FAIL rnd%0d_word%0d: got %h, want %h", r, k, got[k], {init + 32'(k / 4), 2'(k % 4)}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_len0();
    test_len4();
    test_len6();
    test_overflow();
    test_start_ignored();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
